fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle MIPS core, directly upstream of the main control decoder. Holds the PC, fetches one instruction word per instruction from instruction memory over a req/ready handshake, and presents the decoded fields (opcode, funct, register indices, immediates) to the control decoder and datapath. Once the datapath signals completion, it computes the next PC from the decoder's Branch/Jump outcome.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit_npc.sv | 30 +++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

  // Branch displacement in bytes: sign-extended word offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel (single outstanding word).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC: jump > taken branch > sequential, all modulo 2^32.
module fetch_unit_npc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_idx,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] o_pc4,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc4;
  logic [31:0] w_jtarget;
  logic [31:0] w_btarget;

  assign w_pc4     = i_pc + INSTR_BYTES;
  assign w_jtarget = {w_pc4[31:28], i_idx, 2'b00};
  assign w_btarget = w_pc4 + br_offset(i_idx[15:0]);

  always_comb begin
    o_npc = w_pc4;
    if (i_jump)                 o_npc = w_jtarget;
    else if (i_branch && i_zero) o_npc = w_btarget;
  end

  assign o_pc4 = w_pc4;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: holds PC, fetches one word per instruction, retires on inst_done.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  fetch_unit_if.master imem,
  output logic         inst_valid,
  output logic [31:0]  instr,
  output logic [5:0]   INSTop,
  output logic [5:0]   funct,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [15:0]  imm16,
  output logic [31:0]  pc,
  output logic [31:0]  link_addr,
  input  logic         inst_done,
  input  logic         Branch,
  input  logic         Jump,
  input  logic         zero,
  output logic [31:0]  retire_cnt
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic [31:0] r_retire_cnt;
  logic        w_fetch_fire;
  logic        w_retire;
  logic [31:0] w_pc4;
  logic [31:0] w_npc;

  fetch_unit_npc u_npc (
    .i_pc     (r_pc),
    .i_idx    (r_instr[25:0]),
    .i_branch (Branch),
    .i_jump   (Jump),
    .i_zero   (zero),
    .o_pc4    (w_pc4),
    .o_npc    (w_npc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fetch_fire = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE:  if (run) w_state_nxt = S_FETCH;
      S_FETCH: if (imem.imem_ready) begin
                 w_fetch_fire = 1'b1;
                 w_state_nxt  = S_EXEC;
               end
      S_EXEC:  if (inst_done) begin
                 w_retire    = 1'b1;
                 w_state_nxt = run ? S_FETCH : S_IDLE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request is a flop so imem sees a glitch-free level that only moves on edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_req        <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_req <= (w_state_nxt == S_FETCH);
      if (w_fetch_fire) r_instr <= imem.imem_rdata;
      if (w_retire) begin
        r_pc         <= w_npc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign inst_valid     = (r_state == S_EXEC);
  assign instr          = r_instr;
  assign INSTop         = r_instr[31:26];
  assign rs             = r_instr[25:21];
  assign rt             = r_instr[20:16];
  assign rd             = r_instr[15:11];
  assign funct          = r_instr[5:0];
  assign imm16          = r_instr[15:0];
  assign pc             = r_pc;
  assign link_addr      = w_pc4;
  assign retire_cnt     = r_retire_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus stall/reset/wrap sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC default)
  logic        rst, run, inst_done, Branch, Jump, zero;
  logic        inst_valid;
  logic [31:0] instr, pc, link_addr, retire_cnt;
  logic [5:0]  INSTop, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  fetch_unit_if imem_if();

  fetch_unit dut (
    .clk(clk), .rst(rst), .run(run), .imem(imem_if.master),
    .inst_valid(inst_valid), .instr(instr), .INSTop(INSTop), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .pc(pc), .link_addr(link_addr),
    .inst_done(inst_done), .Branch(Branch), .Jump(Jump), .zero(zero),
    .retire_cnt(retire_cnt)
  );

  // second DUT reset to the top of the address space for the wrap case
  logic        w_rst, w_run, w_done;
  logic        w_valid;
  logic [31:0] w_instr, w_pc, w_link, w_rcnt;
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  fetch_unit_if wimem_if();

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst), .run(w_run), .imem(wimem_if.master),
    .inst_valid(w_valid), .instr(w_instr), .INSTop(w_op), .funct(w_fn),
    .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm16(w_imm), .pc(w_pc), .link_addr(w_link),
    .inst_done(w_done), .Branch(1'b0), .Jump(1'b0), .zero(1'b0),
    .retire_cnt(w_rcnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int i;
    for (i = 0; i < 20 && imem_if.imem_req !== 1'b1; i++) tick();
    chk({nm, "_req_seen"}, {31'd0, imem_if.imem_req}, 32'd1);
  endtask

  // fetch + retire one instruction with no field checks
  task automatic exec_one(input logic [31:0] word);
    wait_req("exec_one");
    imem_if.imem_ready = 1'b1; imem_if.imem_rdata = word;
    tick();
    imem_if.imem_ready = 1'b0; inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic        br, jmp, z;
    logic [31:0] exp_pc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{32'h2008_0005, 0,0,0, 32'h3000, 6'h08, 6'h05, 5'd0, 5'd8, 5'd0,  16'h0005, 32'h3004};
    vt[1] = '{32'h0022_1820, 0,0,0, 32'h3004, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3,  16'h1820, 32'h3008};
    vt[2] = '{32'h8C45_0004, 0,0,1, 32'h3008, 6'h23, 6'h04, 5'd2, 5'd5, 5'd0,  16'h0004, 32'h300C};
    vt[3] = '{32'h3C01_1234, 1,0,0, 32'h300C, 6'h0F, 6'h34, 5'd0, 5'd1, 5'd2,  16'h1234, 32'h3010};
    vt[4] = '{32'h1022_FFFE, 1,0,1, 32'h3010, 6'h04, 6'h3E, 5'd1, 5'd2, 5'd31, 16'hFFFE, 32'h300C};
    vt[5] = '{32'h0000_0000, 0,0,0, 32'h300C, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h3010};
    vt[6] = '{32'h1022_FFFE, 1,0,0, 32'h3010, 6'h04, 6'h3E, 5'd1, 5'd2, 5'd31, 16'hFFFE, 32'h3014};
    vt[7] = '{32'h0800_0C08, 0,1,0, 32'h3014, 6'h02, 6'h08, 5'd0, 5'd0, 5'd1,  16'h0C08, 32'h3020};
    vt[8] = '{32'h0C00_0C10, 1,1,1, 32'h3020, 6'h03, 6'h10, 5'd0, 5'd0, 5'd1,  16'h0C10, 32'h3040};
    vt[9] = '{32'h0000_0000, 0,0,0, 32'h3040, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h3044};

    rst = 1'b1; run = 1'b0; inst_done = 1'b0; Branch = 1'b0; Jump = 1'b0; zero = 1'b0;
    imem_if.imem_ready = 1'b0; imem_if.imem_rdata = '0;
    w_rst = 1'b1; w_run = 1'b0; w_done = 1'b0;
    wimem_if.imem_ready = 1'b0; wimem_if.imem_rdata = '0;
    #12;
    rst = 1'b0; w_rst = 1'b0;

    // reset state
    chk("rst_pc", pc, 32'h3000);
    chk("rst_link", link_addr, 32'h3004);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fields", {INSTop, funct, rs, rt, rd}, 32'h0);
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_rcnt", retire_cnt, 32'd0);

    // idle holds without run, then one cycle to request
    tick(); tick();
    chk("idle_req", {31'd0, imem_if.imem_req}, 32'd0);
    run = 1'b1;
    tick();
    chk("idle_to_req", {31'd0, imem_if.imem_req}, 32'd1);

    for (int k = 0; k < 10; k++) begin
      wait_req($sformatf("v%0d", k));
      chk($sformatf("v%0d_addr", k), imem_if.imem_addr, vt[k].exp_pc);
      chk($sformatf("v%0d_valid_fetch", k), {31'd0, inst_valid}, 32'd0);
      imem_if.imem_ready = 1'b1; imem_if.imem_rdata = vt[k].word;
      tick();
      imem_if.imem_ready = 1'b0; imem_if.imem_rdata = 32'hDEAD_BEEF;
      chk($sformatf("v%0d_valid", k), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("v%0d_req_off", k), {31'd0, imem_if.imem_req}, 32'd0);
      chk($sformatf("v%0d_instr", k), instr, vt[k].word);
      chk($sformatf("v%0d_fields", k), {INSTop, funct, rs, rt, rd},
          {vt[k].op, vt[k].fn, vt[k].rs, vt[k].rt, vt[k].rd});
      chk($sformatf("v%0d_imm", k), {16'd0, imm16}, {16'd0, vt[k].imm});
      chk($sformatf("v%0d_link", k), link_addr, vt[k].exp_pc + 32'd4);
      inst_done = 1'b1; Branch = vt[k].br; Jump = vt[k].jmp; zero = vt[k].z;
      tick();
      inst_done = 1'b0; Branch = 1'b0; Jump = 1'b0; zero = 1'b0;
      chk($sformatf("v%0d_npc", k), imem_if.imem_addr, vt[k].exp_npc);
      chk($sformatf("v%0d_rcnt", k), retire_cnt, k + 1);
      chk($sformatf("v%0d_refetch", k), {31'd0, imem_if.imem_req}, 32'd1);
    end

    // ready held low 5 cycles; stray inst_done and branch inputs ignored
    for (int c = 0; c < 5; c++) begin
      inst_done = (c == 2); Jump = (c == 2);
      chk($sformatf("stall%0d_req", c), {31'd0, imem_if.imem_req}, 32'd1);
      chk($sformatf("stall%0d_addr", c), imem_if.imem_addr, 32'h3044);
      chk($sformatf("stall%0d_valid", c), {31'd0, inst_valid}, 32'd0);
      tick();
    end
    inst_done = 1'b0; Jump = 1'b0;
    chk("stall_rcnt", retire_cnt, 32'd10);
    chk("stall_addr_end", imem_if.imem_addr, 32'h3044);
    imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 32'h2008_0005;
    tick();
    imem_if.imem_ready = 1'b0;
    chk("stall_capture", instr, 32'h2008_0005);
    chk("stall_valid", {31'd0, inst_valid}, 32'd1);

    // run dropped before retire: pc advances, goes idle
    run = 1'b0; inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("drop_pc", pc, 32'h3048);
    chk("drop_rcnt", retire_cnt, 32'd11);
    tick();
    chk("drop_idle_req", {31'd0, imem_if.imem_req}, 32'd0);
    run = 1'b1;
    tick();
    chk("resume_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("resume_addr", imem_if.imem_addr, 32'h3048);

    // reset mid-FETCH (req high, ready low)
    rst = 1'b1;
    #1;
    chk("rstf_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rstf_pc", pc, 32'h3000);
    chk("rstf_rcnt", retire_cnt, 32'd0);
    chk("rstf_valid", {31'd0, inst_valid}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    exec_one(32'h0000_0000);
    exec_one(32'h0000_0000);
    wait_req("rste");
    chk("rste_addr", imem_if.imem_addr, 32'h3008);
    imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 32'h0C00_0C10;
    tick();
    imem_if.imem_ready = 1'b0;
    chk("rste_valid_pre", {31'd0, inst_valid}, 32'd1);

    // reset mid-EXEC with inst_done/Jump pending: no retire, no pc update
    inst_done = 1'b1; Jump = 1'b1;
    rst = 1'b1;
    #1;
    chk("rste_pc", pc, 32'h3000);
    chk("rste_rcnt", retire_cnt, 32'd0);
    chk("rste_valid", {31'd0, inst_valid}, 32'd0);
    chk("rste_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rste_instr", instr, 32'h0);
    chk("rste_link", link_addr, 32'h3004);
    tick();
    chk("rste_hold_pc", pc, 32'h3000);
    chk("rste_hold_rcnt", retire_cnt, 32'd0);
    inst_done = 1'b0; Jump = 1'b0; run = 1'b0;
    rst = 1'b0;

    // PC wrap on the second instance
    w_run = 1'b1;
    begin
      int i;
      for (i = 0; i < 20 && wimem_if.imem_req !== 1'b1; i++) tick();
    end
    chk("wrap_req_seen", {31'd0, wimem_if.imem_req}, 32'd1);
    chk("wrap_addr", wimem_if.imem_addr, 32'hFFFF_FFFC);
    wimem_if.imem_ready = 1'b1; wimem_if.imem_rdata = 32'h0022_1820;
    tick();
    wimem_if.imem_ready = 1'b0;
    chk("wrap_link", w_link, 32'h0000_0000);
    w_done = 1'b1;
    tick();
    w_done = 1'b0;
    chk("wrap_npc", wimem_if.imem_addr, 32'h0000_0000);
    chk("wrap_rcnt", w_rcnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=stuck required=finish");
    $fatal(1, "timeout");
  end

endmodule
